id_stage: RTL and testbench

Instruction decode stage of the pipelined core. It takes the 32-bit instruction word from the fetch stage on `id_instr` every cycle, decodes fields and operation class, and reads two source operands from a 32x32 register file. Register-file writes arrive from writeback. It detects load-use hazards and stalls fetch, and it latches HALT. Results are delivered one cycle later as a registered bundle to the execute stage.

---
 rtl/id_pkg.sv | 54 +++++
 rtl/id_regfile.sv | 45 ++++
 rtl/id_stage.sv | 125 ++++++++++++
 tb/tb_id_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared decode definitions for id_stage: opcodes, instruction field positions,
// FSM states and the control half of the execute bundle.
package id_pkg;

    localparam int REG_AW = 5;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ALU  = 6'h01;
    localparam logic [5:0] OP_ADDI = 6'h02;
    localparam logic [5:0] OP_LW   = 6'h03;
    localparam logic [5:0] OP_SW   = 6'h04;
    localparam logic [5:0] OP_BEQ  = 6'h05;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RD_HI  = 25;
    localparam int RD_LO  = 21;
    localparam int RS_HI  = 20;
    localparam int RS_LO  = 16;
    localparam int RT_HI  = 15;
    localparam int RT_LO  = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;
    localparam int FN_HI  = 5;
    localparam int FN_LO  = 0;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_HALTED = 2'd2
    } id_state_t;

    typedef struct packed {
        logic        valid;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic [4:0]  rd;
    } ex_ctrl_t;

    function automatic logic is_valid_op(input logic [5:0] op);
        case (op)
            OP_ALU, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_HALT: return 1'b1;
            OP_NOP:                                         return 1'b0;
            default:                                        return 1'b0;
        endcase
    endfunction

    // Second read port carries rt, or rd for SW; ADDI and LW use those bits as immediate.
    function automatic logic reads_port_b(input logic [5:0] op);
        return (op == OP_ALU) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/id_regfile.sv
// Register file for id_stage: two combinational reads, one synchronous write, r0 reads zero.
// Define ID_BYPASS_EN to forward same-cycle writeback data onto the read ports.
module id_regfile
    import id_pkg::*;
#(
    parameter int NREG = 32,
    parameter int XLEN = 32
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [REG_AW-1:0] i_ra_addr,
    input  logic [REG_AW-1:0] i_rb_addr,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_wa,
    input  logic [XLEN-1:0]   i_wd,
    output logic [XLEN-1:0]   o_ra_data,
    output logic [XLEN-1:0]   o_rb_data
);

    logic [XLEN-1:0] r_regs [NREG];

    // NOTE: the whole array is reset because every architectural register must come up as 0.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_wa != '0)) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    // NOTE: outputs get a default before any conditional override so no latch can be inferred.
    always_comb begin
        o_ra_data = r_regs[i_ra_addr];
        o_rb_data = r_regs[i_rb_addr];
`ifdef ID_BYPASS_EN
        if (i_we && (i_wa == i_ra_addr)) o_ra_data = i_wd;
        if (i_we && (i_wa == i_rb_addr)) o_rb_data = i_wd;
`endif
        if (i_ra_addr == '0) o_ra_data = '0;
        if (i_rb_addr == '0) o_rb_data = '0;
    end

endmodule

// File: rtl/id_stage.sv
// Decode stage: field decode, operand read, load-use stall and HALT latch, registered bundle to execute.
// Same-cycle writeback forwarding is enabled by defining ID_BYPASS_EN.
module id_stage
    import id_pkg::*;
#(
    parameter int NREG = 32,
    parameter int XLEN = 32
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    input  logic [31:0]     id_instr,
    output logic            fe_stall,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    output logic [5:0]      ex_op,
    output logic [5:0]      ex_funct,
    output logic [4:0]      ex_rd,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [XLEN-1:0] ex_imm,
    output logic            halted
);

    logic [5:0]      w_op;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs;
    logic [4:0]      w_rt;
    logic [4:0]      w_rb_addr;
    logic [5:0]      w_funct;
    logic [15:0]     w_imm;
    logic [XLEN-1:0] w_ra_data;
    logic [XLEN-1:0] w_rb_data;
    logic            w_hazard;

    id_state_t       r_state;
    ex_ctrl_t        r_ex;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_imm;
    logic            r_halted;

    assign w_op      = id_instr[OP_HI:OP_LO];
    assign w_rd      = id_instr[RD_HI:RD_LO];
    assign w_rs      = id_instr[RS_HI:RS_LO];
    assign w_rt      = id_instr[RT_HI:RT_LO];
    assign w_funct   = id_instr[FN_HI:FN_LO];
    assign w_imm     = id_instr[IMM_HI:IMM_LO];
    assign w_rb_addr = (w_op == OP_SW) ? w_rd : w_rt;

    id_regfile #(
        .NREG (NREG),
        .XLEN (XLEN)
    ) u_regfile (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .i_ra_addr (w_rs),
        .i_rb_addr (w_rb_addr),
        .i_we      (wb_en),
        .i_wa      (wb_addr),
        .i_wd      (wb_data),
        .o_ra_data (w_ra_data),
        .o_rb_data (w_rb_data)
    );

    // A load in execute whose result the incoming word needs; a bubble bundle never matches.
    assign w_hazard = r_ex.valid && (r_ex.op == OP_LW) && (r_ex.rd != '0) &&
                      ((is_valid_op(w_op) && (w_rs == r_ex.rd)) ||
                       (reads_port_b(w_op) && (w_rb_addr == r_ex.rd)));

    assign fe_stall = (r_state == ST_RUN) && w_hazard;

    // NOTE: state and outputs are registers, so every assignment here is non-blocking.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state  <= ST_RUN;
            r_ex     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_imm    <= '0;
            r_halted <= 1'b0;
        end else begin
            r_ex  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_imm <= '0;
            case (r_state)
                ST_RUN, ST_STALL: begin
                    if (fe_stall) begin
                        r_state <= ST_STALL;
                    end else if (is_valid_op(w_op)) begin
                        r_ex.valid <= 1'b1;
                        r_ex.op    <= w_op;
                        r_ex.funct <= (w_op == OP_ALU) ? w_funct : 6'd0;
                        r_ex.rd    <= ((w_op == OP_SW) || (w_op == OP_BEQ)) ? 5'd0 : w_rd;
                        r_a        <= w_ra_data;
                        r_b        <= w_rb_data;
                        r_imm      <= {{(XLEN-16){w_imm[15]}}, w_imm};
                        if (w_op == OP_HALT) begin
                            r_state  <= ST_HALTED;
                            r_halted <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_HALTED: r_state <= ST_HALTED;
                default:   r_state <= ST_RUN;
            endcase
        end
    end

    assign ex_valid = r_ex.valid;
    assign ex_op    = r_ex.op;
    assign ex_funct = r_ex.funct;
    assign ex_rd    = r_ex.rd;
    assign ex_a     = r_a;
    assign ex_b     = r_b;
    assign ex_imm   = r_imm;
    assign halted   = r_halted;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed literal cases, then randomized traffic
// compared every cycle against a behavioural model of the decode stage.
module tb_id_stage;

    logic        CLOCK_50;
    logic        reset;
    logic [31:0] id_instr;
    logic        fe_stall;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic [5:0]  ex_op;
    logic [5:0]  ex_funct;
    logic [4:0]  ex_rd;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [31:0] ex_imm;
    logic        halted;

    int          n_vec = 0;
    int          n_mis = 0;
    bit          cmp_en = 1'b0;
    logic        st_seen = 1'b0;
    logic [31:0] r_ins;

    id_stage #(
        .NREG (32),
        .XLEN (32)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .id_instr (id_instr),
        .fe_stall (fe_stall),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .ex_valid (ex_valid),
        .ex_op    (ex_op),
        .ex_funct (ex_funct),
        .ex_rd    (ex_rd),
        .ex_a     (ex_a),
        .ex_b     (ex_b),
        .ex_imm   (ex_imm),
        .halted   (halted)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [32];
    logic        m_valid;
    logic [5:0]  m_op;
    logic [5:0]  m_funct;
    logic [4:0]  m_rd;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [31:0] m_imm;
    logic        m_halted;

    // Does instruction word ins use register r as a source?
    function automatic logic m_reads(input logic [31:0] ins, input logic [4:0] r);
        logic [5:0] op;
        op = ins[31:26];
        case (op)
            6'h01, 6'h05, 6'h3F: return (ins[20:16] == r) || (ins[15:11] == r);
            6'h02, 6'h03:        return (ins[20:16] == r);
            6'h04:               return (ins[20:16] == r) || (ins[25:21] == r);
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic m_stall();
        return !m_halted && m_valid && (m_op == 6'h03) && (m_rd != 5'd0) && m_reads(id_instr, m_rd);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef ID_BYPASS_EN
        if (wb_en && (wb_addr == a)) return wb_data;
`endif
        return m_regs[a];
    endfunction

    always @(posedge CLOCK_50 or posedge reset) begin : model
        logic [5:0] op;
        logic       st;
        if (reset) begin
            for (int k = 0; k < 32; k++) m_regs[k] = 32'd0;
            m_valid = 0; m_op = 0; m_funct = 0; m_rd = 0;
            m_a = 0; m_b = 0; m_imm = 0; m_halted = 0;
        end else begin
            st = m_stall();
            op = id_instr[31:26];
            if (m_halted || st || !(op inside {6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h3F})) begin
                m_valid = 0; m_op = 0; m_funct = 0; m_rd = 0;
                m_a = 0; m_b = 0; m_imm = 0;
            end else begin
                m_valid = 1;
                m_op    = op;
                m_funct = (op == 6'h01) ? id_instr[5:0] : 6'd0;
                m_rd    = (op == 6'h04 || op == 6'h05) ? 5'd0 : id_instr[25:21];
                m_a     = m_read(id_instr[20:16]);
                m_b     = m_read((op == 6'h04) ? id_instr[25:21] : id_instr[15:11]);
                m_imm   = 32'(signed'(id_instr[15:0]));
                if (op == 6'h3F) m_halted = 1;
            end
            if (wb_en && (wb_addr != 5'd0)) m_regs[wb_addr] = wb_data;
        end
    end

    always @(negedge CLOCK_50) begin
        if (cmp_en) begin
            check("ex_valid", ex_valid, m_valid);
            check("ex_op",    ex_op,    m_op);
            check("ex_funct", ex_funct, m_funct);
            check("ex_rd",    ex_rd,    m_rd);
            check("ex_a",     ex_a,     m_a);
            check("ex_b",     ex_b,     m_b);
            check("ex_imm",   ex_imm,   m_imm);
            check("halted",   halted,   m_halted);
            check("fe_stall", fe_stall, m_stall());
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [15:0] imm);
        return {op, rd, rs, imm};
    endfunction

    function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [5:0] fn);
        return {op, rd, rs, rt, 5'd0, fn};
    endfunction

    function automatic logic [31:0] rand_instr();
        int unsigned r;
        logic [5:0]  op;
        r = $urandom_range(0, 99);
        if (r < 8)       op = 6'h00;
        else if (r < 28) op = 6'h01;
        else if (r < 43) op = 6'h02;
        else if (r < 63) op = 6'h03;
        else if (r < 76) op = 6'h04;
        else if (r < 90) op = 6'h05;
        else if (r < 92) op = 6'h3F;
        else             op = 6'($urandom);
        return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 11'($urandom)};
    endfunction

    // Called at posedge+1; returns at the next posedge+1 with fe_stall sampled mid-cycle.
    task automatic drive(input logic [31:0] ins, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input bit rst_pulse);
        id_instr = ins;
        wb_en    = we;
        wb_addr  = wa;
        wb_data  = wd;
        if (rst_pulse) begin
            #1 reset = 1'b1;
            #2 reset = 1'b0;
        end
        @(negedge CLOCK_50);
        st_seen = fe_stall;
        @(posedge CLOCK_50);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_mis=%0d", n_mis);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; id_instr = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
        @(posedge CLOCK_50);
        @(posedge CLOCK_50);
        #1;
        reset  = 1'b0;
        cmp_en = 1'b1;
        check("rst_valid",  ex_valid, 0);
        check("rst_halted", halted,   0);
        check("rst_stall",  fe_stall, 0);

        repeat (3) drive(32'd0, 0, 0, 0, 0);
        check("nop_valid", ex_valid, 0);
        check("nop_op",    ex_op,    0);
        check("nop_a",     ex_a,     0);
        check("nop_imm",   ex_imm,   0);

        drive(32'd0, 1, 5'd3, 32'h0000_0005, 0);
        drive(mk(6'h02, 5'd4, 5'd3, 16'hFFFE), 0, 0, 0, 0);
        check("addi_valid", ex_valid, 1);
        check("addi_a",     ex_a,     32'h0000_0005);
        check("addi_imm",   ex_imm,   32'hFFFF_FFFE);
        check("addi_rd",    ex_rd,    4);
        check("addi_op",    ex_op,    6'h02);

        drive(mk(6'h03, 5'd7, 5'd0, 16'h0010), 0, 0, 0, 0);
        check("lw_nostall", st_seen, 0);
        drive(mk_r(6'h01, 5'd8, 5'd7, 5'd3, 6'h21), 0, 0, 0, 0);
        check("lu_stall",  st_seen,  1);
        check("lu_bubble", ex_valid, 0);
        drive(mk_r(6'h01, 5'd8, 5'd7, 5'd3, 6'h21), 0, 0, 0, 0);
        check("lu_release", st_seen,  0);
        check("lu_valid",   ex_valid, 1);
        check("lu_op",      ex_op,    6'h01);
        check("lu_funct",   ex_funct, 6'h21);
        check("lu_rd",      ex_rd,    8);
        check("lu_b",       ex_b,     32'h0000_0005);

        drive(mk(6'h02, 5'd1, 5'd5, 16'h0000), 1, 5'd5, 32'hA5A5_A5A5, 0);
`ifdef ID_BYPASS_EN
        check("bypass_a", ex_a, 32'hA5A5_A5A5);
`else
        check("bypass_a", ex_a, 32'h0000_0000);
`endif
        drive(mk(6'h02, 5'd1, 5'd5, 16'h0000), 0, 0, 0, 0);
        check("after_wb_a", ex_a, 32'hA5A5_A5A5);

        drive(32'd0, 1, 5'd0, 32'h0000_1234, 0);
        drive(mk(6'h02, 5'd2, 5'd0, 16'h7FFF), 0, 0, 0, 0);
        check("r0_a",    ex_a,   0);
        check("imm_pos", ex_imm, 32'h0000_7FFF);

        drive(mk(6'h04, 5'd3, 5'd4, 16'h8000), 0, 0, 0, 0);
        check("sw_rd",  ex_rd,  0);
        check("sw_b",   ex_b,   32'h0000_0005);
        check("sw_imm", ex_imm, 32'hFFFF_8000);

        drive(mk(6'h03, 5'd6, 5'd0, 16'h0000), 0, 0, 0, 0);
        drive(mk(6'h3F, 5'd0, 5'd6, 16'h0000), 0, 0, 0, 0);
        check("halt_stall",  st_seen,  1);
        check("halt_bubble", ex_valid, 0);
        check("halt_wait",   halted,   0);
        drive(mk(6'h3F, 5'd0, 5'd6, 16'h0000), 0, 0, 0, 0);
        check("halt_valid", ex_valid, 1);
        check("halt_op",    ex_op,    6'h3F);
        check("halted",     halted,   1);
        repeat (2) begin
            drive(mk_r(6'h01, 5'd1, 5'd2, 5'd3, 6'h01), 0, 0, 0, 0);
            check("hlt_bubble", ex_valid, 0);
            check("hlt_nostall", st_seen, 0);
        end
        drive(mk(6'h02, 5'd4, 5'd3, 16'h0001), 0, 0, 0, 1);
        check("rst_unhalt",  halted,   0);
        check("rst_resume",  ex_valid, 1);
        check("rst_cleared", ex_a,     0);

        r_ins = 32'd0;
        for (int i = 0; i < 3000; i++) begin
            if (!st_seen) r_ins = rand_instr();
            drive(r_ins, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  $urandom, ($urandom_range(0, 59) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
